// File: rtl/sw_debounce.sv
// Per-bit two-flop synchroniser and debouncer for the board slide switches.
// Produces stable levels plus single-cycle rise/fall strobes and a combined change flag.
module sw_debounce #(
    parameter int               WIDTH     = 4,
    parameter int               DB_CYCLES = 120000,
    parameter logic [WIDTH-1:0] INIT      = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_o,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_chg
);

    localparam int CW = ($clog2(DB_CYCLES) > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic [WIDTH-1:0] s1_r;
    logic [WIDTH-1:0] s2_r;
    logic [CW-1:0]    cnt_r     [WIDTH];
    logic [CW-1:0]    cnt_nxt_s [WIDTH];
    logic [WIDTH-1:0] accept_s;
    logic [WIDTH-1:0] sw_nxt_s;
    logic [WIDTH-1:0] rise_nxt_s;
    logic [WIDTH-1:0] fall_nxt_s;

    // Two-stage synchroniser; metastability is confined to s1_r.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r <= INIT;
            s2_r <= INIT;
        end else begin
            s1_r <= sw_raw;
            s2_r <= s1_r;
        end
    end

    // Next-state for each bit's counter, level and strobes.
    always_comb begin
        accept_s   = {WIDTH{1'b0}};
        sw_nxt_s   = sw_o;
        rise_nxt_s = {WIDTH{1'b0}};
        fall_nxt_s = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt_s[i] = {CW{1'b0}};
            if (s2_r[i] == sw_o[i]) begin
                cnt_nxt_s[i] = {CW{1'b0}};
            end else if (cnt_r[i] == CNT_MAX) begin
                accept_s[i]   = 1'b1;
                sw_nxt_s[i]   = s2_r[i];
                rise_nxt_s[i] = s2_r[i];
                fall_nxt_s[i] = ~s2_r[i];
                cnt_nxt_s[i]  = {CW{1'b0}};
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + CW'(1);
            end
        end
    end

    // Debounce counters; cleared on reset, on any matching cycle and on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= {CW{1'b0}};
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

    // Registered outputs: strobes coincide with the first cycle of the new level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_o    <= INIT;
            sw_rise <= {WIDTH{1'b0}};
            sw_fall <= {WIDTH{1'b0}};
            sw_chg  <= 1'b0;
        end else begin
            sw_o    <= sw_nxt_s;
            sw_rise <= rise_nxt_s;
            sw_fall <= fall_nxt_s;
            sw_chg  <= |accept_s;
        end
    end

endmodule

// File: tb/tb_sw_debounce.sv
// Self-checking bench for sw_debounce: directed scenarios plus random stimulus
// compared against a sliding-window reference model.
`timescale 1ns/1ps
module tb_sw_debounce;

    localparam int W  = 4;
    localparam int DB = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] sw_raw = 4'b0000;
    logic [W-1:0] sw_o;
    logic [W-1:0] sw_rise;
    logic [W-1:0] sw_fall;
    logic         sw_chg;

    int checks = 0;
    int failures = 0;

    // Reference model state: raw samples delayed two edges, then a window of
    // the last DB synchronised samples. A bit flips when the whole window disagrees.
    logic [W-1:0] h1, h2;
    logic [W-1:0] win [DB];
    logic [W-1:0] m_out, m_rise, m_fall;
    logic         m_chg;

    sw_debounce #(.WIDTH(W), .DB_CYCLES(DB), .INIT(4'b0000)) dut (
        .clk(clk), .rst_n(rst_n), .sw_raw(sw_raw),
        .sw_o(sw_o), .sw_rise(sw_rise), .sw_fall(sw_fall), .sw_chg(sw_chg)
    );

    always #41.667 clk = ~clk;

    task automatic model_reset();
        h1 = 4'b0000; h2 = 4'b0000;
        m_out = 4'b0000; m_rise = 4'b0000; m_fall = 4'b0000; m_chg = 1'b0;
        for (int i = 0; i < DB; i++) win[i] = 4'b0000;
    endtask

    task automatic tick();
        logic [W-1:0] s2_pre;
        bit all_diff;
        @(posedge clk);
        s2_pre = h2;
        h2 = h1;
        h1 = sw_raw;
        for (int i = DB - 1; i > 0; i--) win[i] = win[i-1];
        win[0] = s2_pre;
        m_rise = 4'b0000;
        m_fall = 4'b0000;
        for (int b = 0; b < W; b++) begin
            all_diff = 1'b1;
            for (int i = 0; i < DB; i++) if (win[i][b] == m_out[b]) all_diff = 1'b0;
            if (all_diff) begin
                m_out[b] = ~m_out[b];
                if (m_out[b]) m_rise[b] = 1'b1;
                else          m_fall[b] = 1'b1;
            end
        end
        m_chg = |{m_rise, m_fall};
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sw_raw = 4'b1111;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if ({sw_o, sw_rise, sw_fall, sw_chg} !== 13'b0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got=%b required=0", i, {sw_o, sw_rise, sw_fall, sw_chg});
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if (sw_o !== 4'b1111) begin
            failures++;
            $display("FAIL reset_release_accept got=%b required=1111", sw_o);
        end
        #20 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({sw_o, sw_rise, sw_fall, sw_chg} !== 13'b0) begin
            failures++;
            $display("FAIL reset_async got=%b required=0", {sw_o, sw_rise, sw_fall, sw_chg});
        end
        sw_raw = 4'b0000;
        #9 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_clean_press();
        int rises = 0, falls = 0, chgs = 0;
        sw_raw = 4'b0001;
        for (int i = 1; i <= 9; i++) begin
            tick();
            checks++;
            if ({sw_o, sw_rise, sw_fall, sw_chg} !== {m_out, m_rise, m_fall, m_chg}) begin
                failures++;
                $display("FAIL press_model cyc=%0d got=%b expected=%b", i, {sw_o, sw_rise, sw_fall, sw_chg}, {m_out, m_rise, m_fall, m_chg});
            end
            checks++;
            if (sw_o !== ((i >= 6) ? 4'b0001 : 4'b0000)) begin
                failures++;
                $display("FAIL press_latency cyc=%0d got=%b", i, sw_o);
            end
            if (sw_rise == 4'b0001) rises++;
            if (sw_fall != 4'b0000) falls++;
            if (sw_chg) chgs++;
        end
        checks++;
        if (rises != 1 || falls != 0 || chgs != 1) begin
            failures++;
            $display("FAIL press_strobes rises=%0d falls=%0d chgs=%0d required 1/0/1", rises, falls, chgs);
        end
        sw_raw = 4'b0000;
        for (int i = 0; i < 8; i++) tick();
    endtask

    task automatic test_bounce();
        logic [11:0] pat;
        int strobes = 0, rises = 0;
        pat = 12'b111_0_111_00000;
        for (int i = 11; i >= 0; i--) begin
            sw_raw = {2'b00, pat[i], 1'b0};
            tick();
            checks++;
            if ({sw_o, sw_rise, sw_fall, sw_chg} !== {m_out, m_rise, m_fall, m_chg}) begin
                failures++;
                $display("FAIL bounce_model cyc=%0d got=%b expected=%b", i, {sw_o, sw_rise, sw_fall, sw_chg}, {m_out, m_rise, m_fall, m_chg});
            end
            if (sw_o != 4'b0000 || sw_chg) strobes++;
        end
        checks++;
        if (strobes != 0) begin
            failures++;
            $display("FAIL bounce_reject changes=%0d required=0", strobes);
        end
        sw_raw = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (sw_rise == 4'b0010) rises++;
        end
        checks++;
        if (rises != 1 || sw_o !== 4'b0010) begin
            failures++;
            $display("FAIL bounce_accept rises=%0d sw_o=%b required 1/0010", rises, sw_o);
        end
    endtask

    task automatic test_release();
        int falls = 0;
        logic [W-1:0] seen = 4'b0000;
        sw_raw = 4'b0000;
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if (sw_o !== ((i >= 6) ? 4'b0000 : 4'b0010)) begin
                failures++;
                $display("FAIL release_latency cyc=%0d got=%b", i, sw_o);
            end
            if (sw_fall != 4'b0000) falls++;
            seen |= sw_fall;
        end
        checks++;
        if (falls != 1 || seen !== 4'b0010) begin
            failures++;
            $display("FAIL release_strobe count=%0d value=%b required 1/0010", falls, seen);
        end
    endtask

    task automatic test_simultaneous();
        int chgs = 0;
        sw_raw = 4'b1010;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (sw_chg) chgs++;
            if (i == 6) begin
                checks++;
                if (sw_rise !== 4'b1010 || sw_chg !== 1'b1 || sw_o !== 4'b1010) begin
                    failures++;
                    $display("FAIL simul_accept rise=%b chg=%b sw_o=%b required 1010/1/1010", sw_rise, sw_chg, sw_o);
                end
            end
        end
        checks++;
        if (chgs != 1) begin
            failures++;
            $display("FAIL simul_chg_count got=%0d required=1", chgs);
        end
        sw_raw = 4'b0000;
        for (int i = 0; i < 8; i++) tick();
    endtask

    task automatic test_reset_mid_count();
        int rises = 0;
        sw_raw = 4'b0100;
        for (int i = 0; i < 4; i++) tick();
        #5 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (sw_o !== 4'b0000) begin
            failures++;
            $display("FAIL midreset_hold got=%b required=0000", sw_o);
        end
        #49 rst_n = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            checks++;
            if (sw_o !== ((i >= 6) ? 4'b0100 : 4'b0000)) begin
                failures++;
                $display("FAIL midreset_latency cyc=%0d got=%b", i, sw_o);
            end
            if (sw_rise == 4'b0100) rises++;
        end
        checks++;
        if (rises != 1) begin
            failures++;
            $display("FAIL midreset_rise count=%0d required=1", rises);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            for (int b = 0; b < W; b++) begin
                if ($urandom_range(0, 5) == 0) sw_raw[b] = ~sw_raw[b];
            end
            tick();
            checks++;
            if ({sw_o, sw_rise, sw_fall, sw_chg} !== {m_out, m_rise, m_fall, m_chg}) begin
                failures++;
                $display("FAIL random_model cyc=%0d got=%b expected=%b", i, {sw_o, sw_rise, sw_fall, sw_chg}, {m_out, m_rise, m_fall, m_chg});
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_release();
        test_simultaneous();
        test_reset_mid_count();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
